// File: rtl/frame_sym_scheduler_if.sv
// Write-request handshake and symbol-buffer bus of frame_sym_scheduler.
//
// Parameters must match the ones given to the frame_sym_scheduler instance.
//
// Signals:
//   wr_req / wr_id / wr_data / wr_ack : UART-side attribute write handshake
//   valid_mask                        : per-ID "buffer entry holds valid data" flags
//   buf_we / buf_re / buf_addr        : buffer strobes and address
//   buf_wdata / buf_rdata             : buffer data (rdata valid one cycle after buf_re)
//
// Modports:
//   slave  : the scheduler (accepts writes, drives the buffer port)
//   master : the environment (write source, buffer storage, mask source)
interface frame_sym_scheduler_if #(
  parameter int unsigned NUM_SYM_BITS = 2,
  parameter int unsigned ATTR_BITS    = 48
);

  logic                         wr_req;
  logic [NUM_SYM_BITS-1:0]      wr_id;
  logic [ATTR_BITS-1:0]         wr_data;
  logic                         wr_ack;
  logic [2**NUM_SYM_BITS-1:0]   valid_mask;
  logic                         buf_we;
  logic                         buf_re;
  logic [NUM_SYM_BITS-1:0]      buf_addr;
  logic [ATTR_BITS-1:0]         buf_wdata;
  logic [ATTR_BITS-1:0]         buf_rdata;

  modport slave (
    input  wr_req,
    input  wr_id,
    input  wr_data,
    input  valid_mask,
    input  buf_rdata,
    output wr_ack,
    output buf_we,
    output buf_re,
    output buf_addr,
    output buf_wdata
  );

  modport master (
    output wr_req,
    output wr_id,
    output wr_data,
    output valid_mask,
    output buf_rdata,
    input  wr_ack,
    input  buf_we,
    input  buf_re,
    input  buf_addr,
    input  buf_wdata
  );

endinterface

// File: rtl/frame_sym_scheduler.sv
// Per-frame symbol scheduler.
//
// On every falling edge of n_vsync the block walks all symbol IDs, reads each
// attribute word from the symbol buffer and presents it to the renderer shadow
// register with a one-cycle sym_load strobe. Between scans the buffer port is
// lent to the UART-side write path.
//
// Ports:
//   i_clk         pixel clock, rising edge
//   rst           asynchronous active-high reset
//   n_vsync       display vsync, active low
//   bus           write handshake + buffer bus (frame_sym_scheduler_if.slave)
//   sym_load      one-cycle load strobe for the renderer shadow register
//   sym_id        ID being loaded (holds last value between loads)
//   sym_attr      attribute word being loaded (holds last value between loads)
//   sym_valid     mask bit of sym_id, sampled when its read was issued
//   frame_done    one-cycle pulse at the end of a scan
//   busy          scan in progress
//   frame_overrun sticky: a vsync edge arrived while a scan was still running
//
// Optional feature (compile-time macro SCHED_SKIP_INVALID_EN):
//   when defined, IDs whose valid_mask bit is 0 are skipped in a single cycle
//   with neither a buffer read nor a load, so sym_valid is always 1 on a load.
//   When undefined, every ID is read and loaded and sym_valid reports the mask.
module frame_sym_scheduler #(
  parameter int unsigned NUM_SYM_BITS = 2,
  parameter int unsigned ATTR_BITS    = 48
) (
  input  logic                    i_clk,
  input  logic                    rst,
  input  logic                    n_vsync,
  frame_sym_scheduler_if.slave    bus,
  output logic                    sym_load,
  output logic [NUM_SYM_BITS-1:0] sym_id,
  output logic [ATTR_BITS-1:0]    sym_attr,
  output logic                    sym_valid,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    frame_overrun
);

  localparam logic [NUM_SYM_BITS-1:0] MaxId = '1;
  localparam logic [NUM_SYM_BITS-1:0] OneId = NUM_SYM_BITS'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StLoad,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_SYM_BITS-1:0] cnt_q, cnt_d;
  logic                    vsync_q;
  logic                    valid_q;
  logic                    overrun_q, overrun_d;
  logic [NUM_SYM_BITS-1:0] sym_id_q;
  logic [ATTR_BITS-1:0]    sym_attr_q;

  logic start;
  logic cur_valid;
  logic cnt_max;
  logic wr_grant;

  // vsync_q resets to 1 so a line already low at reset release reads as an edge.
  assign start     = vsync_q & ~n_vsync;
  assign cur_valid = bus.valid_mask[cnt_q];
  assign cnt_max   = (cnt_q == MaxId);

  // A start event takes the buffer port first; a held wr_req is served in the
  // first idle cycle after the scan. The rst term keeps every output low while
  // reset is asserted, even with wr_req high.
  assign wr_grant = ~rst & (state_q == StIdle) & bus.wr_req & ~start;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: ID counter, vsync history, sticky overrun, load hold
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      vsync_q    <= 1'b1;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sym_id_q   <= '0;
      sym_attr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      vsync_q   <= n_vsync;
      overrun_q <= overrun_d;
      // Mask bit is taken together with the read so it pairs with that data.
      if (state_q == StRead) begin
        valid_q <= cur_valid;
      end
      if (state_q == StLoad) begin
        sym_id_q   <= cnt_q;
        sym_attr_q <= bus.buf_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    // An edge during a scan is flagged only; the running scan is not restarted.
    if (start && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          cnt_d   = '0;
        end
      end
      StRead: begin
`ifdef SCHED_SKIP_INVALID_EN
        if (cur_valid) begin
          state_d = StLoad;
        end else if (cnt_max) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          cnt_d   = cnt_q + OneId;
        end
`else
        state_d = StLoad;
`endif
      end
      StLoad: begin
        // Counter stops at MaxId; it never wraps inside a scan.
        if (cnt_max) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          cnt_d   = cnt_q + OneId;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.wr_ack    = wr_grant;
    bus.buf_we    = wr_grant;
    bus.buf_re    = 1'b0;
    bus.buf_addr  = '0;
    bus.buf_wdata = '0;
    sym_load      = 1'b0;
    sym_id        = sym_id_q;
    sym_attr      = sym_attr_q;
    sym_valid     = 1'b0;
    frame_done    = 1'b0;
    busy          = (state_q != StIdle);
    frame_overrun = overrun_q;

    // Writes are only granted in idle, so buf_we and buf_re are exclusive.
    if (wr_grant) begin
      bus.buf_addr  = bus.wr_id;
      bus.buf_wdata = bus.wr_data;
    end

    unique case (state_q)
      StRead: begin
`ifdef SCHED_SKIP_INVALID_EN
        bus.buf_re = cur_valid;
`else
        bus.buf_re = 1'b1;
`endif
        bus.buf_addr = cnt_q;
      end
      StLoad: begin
        sym_load  = 1'b1;
        sym_id    = cnt_q;
        sym_attr  = bus.buf_rdata;
        sym_valid = valid_q;
      end
      StDone: begin
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
